// File: rtl/mem_write_m1_if.sv
// Stream-in / BRAM-write bundle for the matrix-1 loader.
// The master drives the element stream; the slave (loader) drives the bank write ports.
interface mem_write_m1_if #(
    parameter int D_W = 32,
    parameter int AW  = 4
);
    logic           start;
    logic [D_W-1:0] s_data;
    logic           s_valid;
    logic           s_ready;
    logic           wr_en_bram0;
    logic           wr_en_bram1;
    logic           wr_en_bram2;
    logic [AW-1:0]  wr_addr_bram0;
    logic [AW-1:0]  wr_addr_bram1;
    logic [AW-1:0]  wr_addr_bram2;
    logic [D_W-1:0] wr_data_bram0;
    logic [D_W-1:0] wr_data_bram1;
    logic [D_W-1:0] wr_data_bram2;
    logic           busy;
    logic           done;

    modport master (
        output start, s_data, s_valid,
        input  s_ready,
        input  wr_en_bram0, wr_en_bram1, wr_en_bram2,
        input  wr_addr_bram0, wr_addr_bram1, wr_addr_bram2,
        input  wr_data_bram0, wr_data_bram1, wr_data_bram2,
        input  busy, done
    );

    modport slave (
        input  start, s_data, s_valid,
        output s_ready,
        output wr_en_bram0, wr_en_bram1, wr_en_bram2,
        output wr_addr_bram0, wr_addr_bram1, wr_addr_bram2,
        output wr_data_bram0, wr_data_bram1, wr_data_bram2,
        output busy, done
    );
endinterface

// File: rtl/mem_write_m1.sv
// Loads a row-major MxM element stream into N=3 column-interleaved BRAM banks,
// laid out so bank (c mod N) holds element (r,c) at address (c/N)*M + r.
module mem_write_m1 #(
    parameter int D_W = 32,
    parameter int N   = 3,
    parameter int M   = 6
) (
    input logic           clk,
    input logic           rst_n,
    mem_write_m1_if.slave bus
);
    localparam int AW = $clog2((M * M) / N);
    localparam int GN = M / N;
    localparam int RW = (M > 1) ? $clog2(M) : 1;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int GW = (GN > 1) ? $clog2(GN) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]     state_q;
    logic [RW-1:0]  r_q;
    logic [KW-1:0]  k_q;
    logic [GW-1:0]  g_q;
    logic [2:0]     wr_en_q;
    logic [AW-1:0]  wr_addr_q [3];
    logic [D_W-1:0] wr_data_q [3];

    logic          in_load;
    logic          accept;
    logic          last_beat;
    logic [AW-1:0] addr_c;

    assign in_load   = (state_q == LOAD);
    assign accept    = in_load && bus.s_valid;
    assign last_beat = (r_q == RW'(M - 1)) && (k_q == KW'(N - 1)) && (g_q == GW'(GN - 1));
    // Group index stands in for c/N, so the address needs only a constant multiply.
    assign addr_c    = AW'(g_q) * AW'(M) + AW'(r_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            k_q     <= '0;
            g_q     <= '0;
            wr_en_q <= '0;
            // NOTE: these are plain output registers, not a RAM array, so resetting them is cheap and keeps the bank ports at 0 in reset.
            for (int b = 0; b < 3; b++) begin
                wr_addr_q[b] <= '0;
                wr_data_q[b] <= '0;
            end
        end else begin
            // NOTE: non-blocking default makes each write enable a one-cycle pulse unless re-asserted below.
            wr_en_q <= '0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= LOAD;
                        r_q     <= '0;
                        k_q     <= '0;
                        g_q     <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        for (int b = 0; b < 3; b++) begin
                            if (k_q == KW'(b)) begin
                                wr_en_q[b]   <= 1'b1;
                                wr_addr_q[b] <= addr_c;
                                wr_data_q[b] <= bus.s_data;
                            end
                        end
                        if (k_q == KW'(N - 1)) begin
                            k_q <= '0;
                            if (g_q == GW'(GN - 1)) begin
                                g_q <= '0;
                                r_q <= (r_q == RW'(M - 1)) ? '0 : r_q + RW'(1);
                            end else begin
                                g_q <= g_q + GW'(1);
                            end
                        end else begin
                            k_q <= k_q + KW'(1);
                        end
                        if (last_beat) state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.s_ready       = in_load;
    assign bus.busy          = (state_q == LOAD) || (state_q == DONE);
    assign bus.done          = (state_q == DONE);
    assign bus.wr_en_bram0   = wr_en_q[0];
    assign bus.wr_en_bram1   = wr_en_q[1];
    assign bus.wr_en_bram2   = wr_en_q[2];
    assign bus.wr_addr_bram0 = wr_addr_q[0];
    assign bus.wr_addr_bram1 = wr_addr_q[1];
    assign bus.wr_addr_bram2 = wr_addr_q[2];
    assign bus.wr_data_bram0 = wr_data_q[0];
    assign bus.wr_data_bram1 = wr_data_q[1];
    assign bus.wr_data_bram2 = wr_data_q[2];
endmodule

// File: tb/tb_mem_write_m1.sv
// Directed bench for mem_write_m1 (M=6, N=3): full loads, bubbles, held start,
// mid-load reset and valid-outside-LOAD, with a bank image rebuilt from observed writes.
module tb_mem_write_m1;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mem_write_m1_if #(.D_W(32), .AW(4)) bus ();

    mem_write_m1 #(.D_W(32), .N(3), .M(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Observed-write bookkeeping, sampled on the falling edge.
    logic [31:0] mem [3][16];
    int write_cnt = 0;
    int multi_en  = 0;
    int done_cnt  = 0;
    int done_w2   = 0;
    int writes_at_done = 0;

    always @(negedge clk) begin
        if (int'(bus.wr_en_bram0) + int'(bus.wr_en_bram1) + int'(bus.wr_en_bram2) > 1) multi_en++;
        if (bus.wr_en_bram0) begin mem[0][bus.wr_addr_bram0] = bus.wr_data_bram0; write_cnt++; end
        if (bus.wr_en_bram1) begin mem[1][bus.wr_addr_bram1] = bus.wr_data_bram1; write_cnt++; end
        if (bus.wr_en_bram2) begin mem[2][bus.wr_addr_bram2] = bus.wr_data_bram2; write_cnt++; end
        if (bus.done) begin
            done_cnt++;
            if (bus.wr_en_bram2) done_w2++;
            writes_at_done = write_cnt;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int b = 0; b < 3; b++)
            for (int a = 0; a < 16; a++) mem[b][a] = 32'hDEAD_BEEF;
    endtask

    function automatic logic [2:0] en_vec();
        return {bus.wr_en_bram2, bus.wr_en_bram1, bus.wr_en_bram0};
    endfunction

    task automatic do_start(input bit keep_high);
        bus.start = 1'b1;
        step();
        if (!keep_high) bus.start = 1'b0;
    endtask

    // Sends beats base..base+count-1; optional two-cycle bubble after even beats.
    task automatic send_beats(input int base, input int count, input bit bubbles);
        int waitc;
        for (int i = 0; i < count; i++) begin
            waitc = 0;
            while (bus.s_ready !== 1'b1 && waitc < 20) begin
                step();
                waitc++;
            end
            total++;
            if (bus.s_ready !== 1'b1) begin
                bad++;
                $display("FAIL ready_wait beat=%0d got s_ready=%b want 1", i, bus.s_ready);
            end
            bus.s_valid = 1'b1;
            bus.s_data  = 32'(base + i);
            step();
            if (bubbles && (i % 2 == 0) && i != count - 1) begin
                bus.s_valid = 1'b0;
                repeat (2) begin
                    step();
                    total++;
                    if (en_vec() !== 3'b000) begin
                        bad++;
                        $display("FAIL bubble_no_write beat=%0d got wr_en=%b want 000", i, en_vec());
                    end
                end
            end
        end
    endtask

    task automatic check_mem(input int base, input string tag);
        int r, c, b, a;
        for (int i = 0; i < 36; i++) begin
            r = i / 6;
            c = i % 6;
            b = c % 3;
            a = (c / 3) * 6 + r;
            total++;
            if (mem[b][a] !== 32'(base + i)) begin
                bad++;
                $display("FAIL %s map elem=%0d bank=%0d addr=%0d got %0d want %0d",
                         tag, i, b, a, mem[b][a], base + i);
            end
        end
    endtask

    // Called right after the last beat's accepting edge: DONE cycle is current.
    task automatic check_done_now(input string tag, input int writes_before, input int dones_before);
        total++;
        if (bus.done !== 1'b1 || en_vec() !== 3'b100) begin
            bad++;
            $display("FAIL %s done_with_last got done=%b wr_en=%b want 1/100", tag, bus.done, en_vec());
        end
        total++;
        if (write_cnt - writes_before !== 36) begin
            bad++;
            $display("FAIL %s write_count got %0d want 36", tag, write_cnt - writes_before);
        end
        total++;
        if (done_cnt - dones_before !== 1 || writes_at_done - writes_before !== 36) begin
            bad++;
            $display("FAIL %s done_once got pulses=%0d writes_at_done=%0d want 1/36",
                     tag, done_cnt - dones_before, writes_at_done - writes_before);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
        rst_n = 1'b0;
        repeat (3) step();
        total++;
        if ({bus.s_ready, bus.busy, bus.done, en_vec()} !== 6'b0 ||
            {bus.wr_addr_bram0, bus.wr_addr_bram1, bus.wr_addr_bram2} !== 12'h0 ||
            {bus.wr_data_bram0, bus.wr_data_bram1, bus.wr_data_bram2} !== 96'h0) begin
            bad++;
            $display("FAIL reset_outputs got rdy=%b busy=%b done=%b en=%b a0=%0d d0=%0d want all 0",
                     bus.s_ready, bus.busy, bus.done, en_vec(), bus.wr_addr_bram0, bus.wr_data_bram0);
        end
        rst_n = 1'b1;
        step();
        total++;
        if (bus.s_ready !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset got rdy=%b busy=%b want 0/0", bus.s_ready, bus.busy);
        end
    endtask

    task automatic test_full_load();
        int w0 = write_cnt, d0 = done_cnt;
        clear_mem();
        do_start(1'b0);
        total++;
        if (bus.s_ready !== 1'b1 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL load_entry got rdy=%b busy=%b want 1/1", bus.s_ready, bus.busy);
        end
        send_beats(0, 36, 1'b0);
        bus.s_valid = 1'b0;
        check_done_now("full", w0, d0);
        total++;
        if (bus.wr_addr_bram2 !== 4'd11 || bus.wr_data_bram2 !== 32'd35) begin
            bad++;
            $display("FAIL full last_write got addr=%0d data=%0d want 11/35", bus.wr_addr_bram2, bus.wr_data_bram2);
        end
        step();
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || en_vec() !== 3'b000) begin
            bad++;
            $display("FAIL full back_to_idle got done=%b busy=%b en=%b want 0/0/000", bus.done, bus.busy, en_vec());
        end
        check_mem(0, "full");
        total++;
        if (multi_en !== 0) begin
            bad++;
            $display("FAIL onehot_wr_en got %0d violations want 0", multi_en);
        end
    endtask

    task automatic test_bubbles();
        int w0 = write_cnt, d0 = done_cnt;
        clear_mem();
        do_start(1'b0);
        send_beats(0, 36, 1'b1);
        bus.s_valid = 1'b0;
        check_done_now("bubble", w0, d0);
        step();
        check_mem(0, "bubble");
    endtask

    task automatic test_start_held();
        int w0 = write_cnt, d0 = done_cnt;
        clear_mem();
        do_start(1'b1);
        send_beats(0, 36, 1'b0);
        bus.s_valid = 1'b0;
        check_done_now("held1", w0, d0);
        check_mem(0, "held1");
        // start still high: DONE -> IDLE -> LOAD, then a second load overwrites.
        w0 = write_cnt;
        d0 = done_cnt;
        send_beats(100, 1, 1'b0);
        bus.start = 1'b0;
        send_beats(101, 35, 1'b0);
        bus.s_valid = 1'b0;
        check_done_now("held2", w0 - 0, d0);
        step();
        check_mem(100, "held2");
    endtask

    task automatic test_idle_valid();
        int w0, d0;
        w0 = write_cnt;
        bus.s_valid = 1'b1;
        bus.s_data  = 32'd999;
        repeat (4) step();
        total++;
        if (bus.s_ready !== 1'b0 || write_cnt !== w0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_valid got rdy=%b writes=%0d busy=%b want 0/0/0",
                     bus.s_ready, write_cnt - w0, bus.busy);
        end
        bus.s_valid = 1'b0;
        w0 = write_cnt;
        d0 = done_cnt;
        clear_mem();
        do_start(1'b0);
        send_beats(200, 36, 1'b0);
        // valid stays high into the DONE cycle
        bus.s_data = 32'd999;
        total++;
        if (bus.s_ready !== 1'b0 || bus.done !== 1'b1) begin
            bad++;
            $display("FAIL done_valid got rdy=%b done=%b want 0/1", bus.s_ready, bus.done);
        end
        step();
        total++;
        if (en_vec() !== 3'b000 || write_cnt - w0 !== 36) begin
            bad++;
            $display("FAIL done_valid_no_write got en=%b writes=%0d want 000/36", en_vec(), write_cnt - w0);
        end
        bus.s_valid = 1'b0;
        check_mem(200, "donevalid");
    endtask

    task automatic test_mid_reset();
        int w0 = write_cnt, d0 = done_cnt;
        clear_mem();
        do_start(1'b0);
        send_beats(0, 20, 1'b0);
        bus.s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.s_ready, bus.busy, bus.done, en_vec()} !== 6'b0 ||
            {bus.wr_addr_bram0, bus.wr_addr_bram1, bus.wr_addr_bram2} !== 12'h0 ||
            {bus.wr_data_bram0, bus.wr_data_bram1, bus.wr_data_bram2} !== 96'h0) begin
            bad++;
            $display("FAIL async_reset got rdy=%b busy=%b done=%b en=%b a1=%0d d1=%0d want all 0",
                     bus.s_ready, bus.busy, bus.done, en_vec(), bus.wr_addr_bram1, bus.wr_data_bram1);
        end
        step();
        rst_n = 1'b1;
        repeat (3) step();
        total++;
        if (write_cnt - w0 !== 20 || done_cnt !== d0) begin
            bad++;
            $display("FAIL abort got writes=%0d dones=%0d want 20/0", write_cnt - w0, done_cnt - d0);
        end
        w0 = write_cnt;
        clear_mem();
        do_start(1'b0);
        send_beats(0, 36, 1'b0);
        check_done_now("restart", w0, d0);
        step();
        check_mem(0, "restart");
        total++;
        if (multi_en !== 0) begin
            bad++;
            $display("FAIL onehot_final got %0d violations want 0", multi_en);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_bubbles();
        test_start_held();
        test_idle_valid();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
